// File: rtl/counter_checker_pkg.sv
// counter_checker_pkg
// Shared definitions for the counter checker: verdict FSM state encoding,
// default geometry of the count under check, and the width of the optional
// error counter (present only when COUNTER_CHECKER_ERRCNT_EN is defined).
package counter_checker_pkg;

  // Default geometry: a 5-bit counter checked for 251 post-reset cycles,
  // with an 8-bit cycle index (RUN_CYCLES must stay below 2**CYCLE_W).
  localparam int DEFAULT_WIDTH      = 5;
  localparam int DEFAULT_RUN_CYCLES = 251;
  localparam int DEFAULT_CYCLE_W    = 8;

  // Width of the saturating mismatch counter.
  localparam int ERR_COUNT_W = 8;

  // Verdict FSM: RUN while comparing, PASS/FAIL are terminal until reset.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_e;

endpackage

// File: rtl/counter_checker_gold.sv
// counter_checker_gold
// Gold reference counter. It mirrors the expected behaviour of the upstream
// Counter: 0 in any reset cycle, then +1 per clock wrapping modulo 2**WIDTH.
//
// Ports:
//   clock  - rising-edge clock shared with the upstream Counter
//   reset  - synchronous, active-high reset (same net as the Counter reset)
//   gold   - expected count value for the current cycle
module counter_checker_gold
  import counter_checker_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] gold
);

  // Free-running reference count; natural overflow of the WIDTH-bit add
  // gives the required modulo-2**WIDTH wrap, so wrap is not a special case.
  always_ff @(posedge clock) begin
    if (reset) begin
      gold <= '0;
    end else begin
      gold <= gold + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_checker.sv
// counter_checker
// Compares the registered count of an upstream Counter against a gold model
// for RUN_CYCLES post-reset cycles and reports a PASS/FAIL verdict together
// with details of the first mismatch.
//
// Ports:
//   clock          - rising-edge clock shared with the upstream Counter
//   reset          - synchronous, active-high reset (same net as the Counter)
//   dut_count      - registered count output of the upstream Counter
//   done           - a verdict has been reached (held until reset)
//   pass           - FSM is in PASS
//   fail           - FSM is in FAIL
//   fail_cycle     - cycle index of the first mismatch
//   fail_expected  - gold value at the first mismatch
//   fail_observed  - dut_count at the first mismatch
//   err_count      - saturating count of mismatching cycles
//                    (only with COUNTER_CHECKER_ERRCNT_EN defined)
//
// Configuration macro: COUNTER_CHECKER_ERRCNT_EN
//   Undefined (default): the first mismatch ends the run in FAIL.
//   Defined: the run always lasts RUN_CYCLES cycles, mismatches are counted,
//   and the verdict is taken on the last cycle.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int RUN_CYCLES = DEFAULT_RUN_CYCLES,
  parameter int CYCLE_W    = DEFAULT_CYCLE_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   dut_count,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic [CYCLE_W-1:0] fail_cycle,
  output logic [WIDTH-1:0]   fail_expected,
  output logic [WIDTH-1:0]   fail_observed
`ifdef COUNTER_CHECKER_ERRCNT_EN
  ,
  output logic [ERR_COUNT_W-1:0] err_count
`endif
);

  localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(RUN_CYCLES - 1);

  state_e             state;
  logic [CYCLE_W-1:0] cycle_cnt;
  logic [WIDTH-1:0]   gold;
  logic               mismatch;
  logic               last_cycle;

  counter_checker_gold #(
    .WIDTH (WIDTH)
  ) u_gold (
    .clock (clock),
    .reset (reset),
    .gold  (gold)
  );

  assign mismatch   = (gold != dut_count);
  assign last_cycle = (cycle_cnt == LAST_CYCLE);

  // Verdict outputs are plain decodes of the registered state, so they rise
  // one edge after the deciding comparison and can never both be high.
  assign done = (state != RUN);
  assign pass = (state == PASS);
  assign fail = (state == FAIL);

  // Verdict FSM, cycle counter and first-mismatch capture. Only the RUN state
  // does anything; PASS/FAIL ignore dut_count and freeze every register.
  // A mismatch on the last cycle is checked before the PASS decision so that
  // FAIL always wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      cycle_cnt     <= '0;
      fail_cycle    <= '0;
      fail_expected <= '0;
      fail_observed <= '0;
`ifdef COUNTER_CHECKER_ERRCNT_EN
      err_count     <= '0;
`endif
    end else if (state == RUN) begin
`ifdef COUNTER_CHECKER_ERRCNT_EN
      if (mismatch && (err_count == '0)) begin
        fail_cycle    <= cycle_cnt;
        fail_expected <= gold;
        fail_observed <= dut_count;
      end
      if (mismatch && (err_count != '1)) begin
        err_count <= err_count + ERR_COUNT_W'(1);
      end
      if (last_cycle) begin
        state <= (mismatch || (err_count != '0)) ? FAIL : PASS;
      end else begin
        cycle_cnt <= cycle_cnt + CYCLE_W'(1);
      end
`else
      if (mismatch) begin
        state         <= FAIL;
        fail_cycle    <= cycle_cnt;
        fail_expected <= gold;
        fail_observed <= dut_count;
      end else if (last_cycle) begin
        state <= PASS;
      end else begin
        cycle_cnt <= cycle_cnt + CYCLE_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker
// Directed testbench for counter_checker. The bench plays the role of the
// upstream Counter by driving dut_count = cycle index mod 32, optionally
// replacing selected cycles with a wrong value (7), and checks the verdict
// outputs against hand-computed values.
module tb_counter_checker;

  localparam int W       = 5;
  localparam int CW      = 8;
  localparam int LAST    = 250;
  localparam int BAD_VAL = 7;

  logic          clock;
  logic          reset;
  logic [W-1:0]  dut_count;
  logic          done;
  logic          pass;
  logic          fail;
  logic [CW-1:0] fail_cycle;
  logic [W-1:0]  fail_expected;
  logic [W-1:0]  fail_observed;
`ifdef COUNTER_CHECKER_ERRCNT_EN
  logic [7:0]    err_count;
`endif

  int checks = 0;
  int errors = 0;

  counter_checker dut (
    .clock         (clock),
    .reset         (reset),
    .dut_count     (dut_count),
    .done          (done),
    .pass          (pass),
    .fail          (fail),
    .fail_cycle    (fail_cycle),
    .fail_expected (fail_expected),
    .fail_observed (fail_observed)
`ifdef COUNTER_CHECKER_ERRCNT_EN
    ,
    .err_count     (err_count)
`endif
  );

  // 10 ns free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // All outputs must read zero while in reset or just after it.
  task automatic checkIdle(input string tag);
    checkOutput({tag, ".done"}, 32'(done), 0);
    checkOutput({tag, ".pass"}, 32'(pass), 0);
    checkOutput({tag, ".fail"}, 32'(fail), 0);
    checkOutput({tag, ".fail_cycle"}, 32'(fail_cycle), 0);
    checkOutput({tag, ".fail_expected"}, 32'(fail_expected), 0);
    checkOutput({tag, ".fail_observed"}, 32'(fail_observed), 0);
  endtask

  // Holds reset for n edges, then releases it; the next edge is cycle 0.
  task automatic applyReset(input int n);
    reset     = 1'b1;
    dut_count = '0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
  endtask

  // Drives cycles first..last of a run as a correct counter, except that
  // cycles equal to bad0/bad1/bad2 (-1 = unused) carry BAD_VAL instead.
  task automatic applyStimulus(input int first, input int last,
                               input int bad0, input int bad1, input int bad2);
    for (int k = first; k <= last; k++) begin
      if (k == bad0 || k == bad1 || k == bad2) begin
        dut_count = W'(BAD_VAL);
      end else begin
        dut_count = W'(k);
      end
      @(posedge clock);
      #1;
    end
  endtask

  // Directed scenario sequence.
  initial begin
    reset     = 1'b1;
    dut_count = '0;

    // Multi-cycle reset keeps every output at zero.
    applyReset(2);
    reset = 1'b1;
    checkIdle("reset_hold2");
    applyReset(3);
    checkIdle("reset_hold5");

    // Correct counter, crossing the 31 -> 0 wrap at cycle 32.
    applyStimulus(0, 39, -1, -1, -1);
    checkOutput("wrap.fail", 32'(fail), 0);
    checkOutput("wrap.done", 32'(done), 0);
    applyStimulus(40, LAST - 1, -1, -1, -1);
    checkOutput("pre_last.done", 32'(done), 0);
    checkOutput("pre_last.pass", 32'(pass), 0);
    applyStimulus(LAST, LAST, -1, -1, -1);
    checkOutput("good.pass", 32'(pass), 1);
    checkOutput("good.done", 32'(done), 1);
    checkOutput("good.fail", 32'(fail), 0);
    // Terminal state ignores a wrong dut_count.
    applyStimulus(3, 5, 3, 4, 5);
    checkOutput("good_hold.pass", 32'(pass), 1);
    checkOutput("good_hold.fail", 32'(fail), 0);

    // Reset in the middle of a run clears everything.
    applyReset(1);
    applyStimulus(0, 99, -1, -1, -1);
    applyReset(1);
    checkIdle("mid_run_reset");

`ifndef COUNTER_CHECKER_ERRCNT_EN
    // Single wrong value at cycle 12 stops the run one edge later.
    applyStimulus(0, 11, -1, -1, -1);
    checkOutput("early.fail_before", 32'(fail), 0);
    applyStimulus(12, 12, 12, -1, -1);
    checkOutput("early.fail", 32'(fail), 1);
    checkOutput("early.done", 32'(done), 1);
    checkOutput("early.pass", 32'(pass), 0);
    checkOutput("early.fail_cycle", 32'(fail_cycle), 12);
    checkOutput("early.fail_expected", 32'(fail_expected), 12);
    checkOutput("early.fail_observed", 32'(fail_observed), BAD_VAL);
    applyStimulus(13, 20, -1, -1, -1);
    checkOutput("early_hold.fail_cycle", 32'(fail_cycle), 12);
`else
    // Three wrong values are counted; verdict only at the end of the run.
    applyStimulus(0, 40, 10, 20, 30);
    checkOutput("errcnt.fail_mid", 32'(fail), 0);
    checkOutput("errcnt.count_mid", 32'(err_count), 3);
    applyStimulus(41, LAST, -1, -1, -1);
    checkOutput("errcnt.fail", 32'(fail), 1);
    checkOutput("errcnt.pass", 32'(pass), 0);
    checkOutput("errcnt.count", 32'(err_count), 3);
    checkOutput("errcnt.fail_cycle", 32'(fail_cycle), 10);
    checkOutput("errcnt.fail_expected", 32'(fail_expected), 10);
    checkOutput("errcnt.fail_observed", 32'(fail_observed), BAD_VAL);
`endif

    // Reset after a FAIL verdict, then a fresh run passes.
    applyReset(1);
    checkIdle("post_fail_reset");
`ifdef COUNTER_CHECKER_ERRCNT_EN
    checkOutput("post_fail_reset.err_count", 32'(err_count), 0);
`endif
    applyStimulus(0, LAST, -1, -1, -1);
    checkOutput("fresh.pass", 32'(pass), 1);
    checkOutput("fresh.fail", 32'(fail), 0);

    // Mismatch only on the final cycle: FAIL beats PASS.
    // Gold at cycle 250 is 250 mod 32 = 26.
    applyReset(2);
    applyStimulus(0, LAST, LAST, -1, -1);
    checkOutput("last.fail", 32'(fail), 1);
    checkOutput("last.pass", 32'(pass), 0);
    checkOutput("last.done", 32'(done), 1);
    checkOutput("last.fail_cycle", 32'(fail_cycle), LAST);
    checkOutput("last.fail_expected", 32'(fail_expected), 26);
    checkOutput("last.fail_observed", 32'(fail_observed), BAD_VAL);
`ifdef COUNTER_CHECKER_ERRCNT_EN
    checkOutput("last.err_count", 32'(err_count), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
